// File: rtl/morra_match_driver.sv
// Initiator for the MorraCinese game interface: configures a match, plays it one round per
// clock from two LFSR move generators, tallies per-round outcomes and latches the final result.
module morra_match_driver #(
  parameter logic [15:0] SEED1         = 16'hACE1,
  parameter logic [15:0] SEED2         = 16'h1D2B,
  parameter int          MAX_CYCLES    = 64,
  parameter bit          AVOID_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] cfg_rounds_i,
  output logic       INIZIA,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] result_o,
  output logic [4:0] p1_wins_o,
  output logic [4:0] p2_wins_o,
  output logic [4:0] draws_o,
  output logic [4:0] invalid_o,
  output logic [5:0] rounds_o,
  output logic       timeout_err_o
);

  localparam logic [15:0] SEED1_EFF = (SEED1 == 16'h0000) ? 16'h0001 : SEED1;
  localparam logic [15:0] SEED2_EFF = (SEED2 == 16'h0000) ? 16'h0001 : SEED2;
  // Internal round counter is wide enough to reach MAX_CYCLES even when it exceeds rounds_o.
  localparam int CNT_W = (MAX_CYCLES > 63) ? $clog2(MAX_CYCLES + 1) : 6;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_PLAY, S_DONE} state_t;
  typedef enum logic [1:0] {W_NONE, W_P1, W_P2} winner_t;

  state_t           state;
  winner_t          win, win_nxt;
  logic [1:0]       win_mv, win_mv_nxt;
  logic [15:0]      lfsr1, lfsr2, lfsr1_nxt, lfsr2_nxt;
  logic [CNT_W-1:0] play_cnt, play_cnt_nxt;
  logic [1:0]       mv1_cfg, mv2_cfg, mv1_play, mv2_play;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [1:0] rot_move(input logic [1:0] m);
    return (m == 2'b11) ? 2'b01 : m + 2'b01;
  endfunction

  function automatic logic [1:0] pick_move(input logic [15:0] s, input logic is_winner,
                                           input logic [1:0] last_mv);
    logic [1:0] cand;
    cand = (s[1:0] == 2'b00) ? 2'b01 : s[1:0];
    if (AVOID_ILLEGAL && is_winner && (cand == last_mv))
      cand = rot_move(cand);
    return cand;
  endfunction

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'h1F) ? v : v + 5'd1;
  endfunction

  always_comb begin
    lfsr1_nxt    = lfsr_step(lfsr1);
    lfsr2_nxt    = lfsr_step(lfsr2);
    play_cnt_nxt = play_cnt + CNT_W'(1);
    win_nxt      = win;
    win_mv_nxt   = win_mv;
    if (MANCHE == 2'b01) begin
      win_nxt    = W_P1;
      win_mv_nxt = PRIMO;
    end else if (MANCHE == 2'b10) begin
      win_nxt    = W_P2;
      win_mv_nxt = SECONDO;
    end
    mv1_cfg  = pick_move(lfsr1, win == W_P1, win_mv);
    mv2_cfg  = pick_move(lfsr2, win == W_P2, win_mv);
    // Next round's moves must see this round's outcome and the stepped LFSRs.
    mv1_play = pick_move(lfsr1_nxt, win_nxt == W_P1, win_mv_nxt);
    mv2_play = pick_move(lfsr2_nxt, win_nxt == W_P2, win_mv_nxt);
  end

  assign rounds_o = (play_cnt > CNT_W'(63)) ? 6'h3F : play_cnt[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      INIZIA        <= 1'b0;
      PRIMO         <= 2'b00;
      SECONDO       <= 2'b00;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      result_o      <= 2'b00;
      p1_wins_o     <= 5'd0;
      p2_wins_o     <= 5'd0;
      draws_o       <= 5'd0;
      invalid_o     <= 5'd0;
      play_cnt      <= '0;
      timeout_err_o <= 1'b0;
      lfsr1         <= SEED1_EFF;
      lfsr2         <= SEED2_EFF;
      win           <= W_NONE;
      win_mv        <= 2'b00;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state         <= S_CFG;
            busy_o        <= 1'b1;
            INIZIA        <= 1'b1;
            PRIMO         <= cfg_rounds_i[3:2];
            SECONDO       <= cfg_rounds_i[1:0];
            result_o      <= 2'b00;
            p1_wins_o     <= 5'd0;
            p2_wins_o     <= 5'd0;
            draws_o       <= 5'd0;
            invalid_o     <= 5'd0;
            play_cnt      <= '0;
            timeout_err_o <= 1'b0;
            win           <= W_NONE;
            win_mv        <= 2'b00;
          end
        end
        S_CFG: begin
          state   <= S_PLAY;
          INIZIA  <= 1'b0;
          PRIMO   <= mv1_cfg;
          SECONDO <= mv2_cfg;
        end
        S_PLAY: begin
          play_cnt <= play_cnt_nxt;
          case (MANCHE)
            2'b01:   p1_wins_o <= sat_inc5(p1_wins_o);
            2'b10:   p2_wins_o <= sat_inc5(p2_wins_o);
            2'b11:   draws_o   <= sat_inc5(draws_o);
            default: invalid_o <= sat_inc5(invalid_o);
          endcase
          lfsr1  <= lfsr1_nxt;
          lfsr2  <= lfsr2_nxt;
          win    <= win_nxt;
          win_mv <= win_mv_nxt;
          if (PARTITA != 2'b00) begin
            state    <= S_DONE;
            done_o   <= 1'b1;
            result_o <= PARTITA;
            PRIMO    <= 2'b00;
            SECONDO  <= 2'b00;
          end else if (play_cnt_nxt == MAX_CNT) begin
            state         <= S_DONE;
            done_o        <= 1'b1;
            timeout_err_o <= 1'b1;
            result_o      <= 2'b00;
            PRIMO         <= 2'b00;
            SECONDO       <= 2'b00;
          end else begin
            PRIMO   <= mv1_play;
            SECONDO <= mv2_play;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morra_match_driver.sv
// Bench for morra_match_driver: two instances (move avoidance on/off) share one scripted or random
// MorraCinese stand-in and are compared round by round against a behavioural model of the game rules.
module tb_morra_match_driver;

  localparam logic [15:0] SEED1 = 16'hACE1;
  localparam logic [15:0] SEED2 = 16'h1D2B;
  localparam int          MAXC  = 8;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic [3:0]      cfg_rounds_i;
  logic [1:0]      MANCHE, PARTITA;
  logic [1:0]      iniz, busy, done, tmo;
  logic [1:0][1:0] primo, secondo, result;
  logic [1:0][4:0] p1w, p2w, drw, invw;
  logic [1:0][5:0] rnds;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_l1 [2];
  logic [15:0] m_l2 [2];
  int          m_win [2];
  logic [1:0]  m_wmv [2];
  logic [1:0]  m_mv1 [2];
  logic [1:0]  m_mv2 [2];

  morra_match_driver #(.SEED1(SEED1), .SEED2(SEED2), .MAX_CYCLES(MAXC), .AVOID_ILLEGAL(1'b1)) dut_av (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_rounds_i(cfg_rounds_i),
    .INIZIA(iniz[0]), .PRIMO(primo[0]), .SECONDO(secondo[0]), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .busy_o(busy[0]), .done_o(done[0]), .result_o(result[0]), .p1_wins_o(p1w[0]), .p2_wins_o(p2w[0]),
    .draws_o(drw[0]), .invalid_o(invw[0]), .rounds_o(rnds[0]), .timeout_err_o(tmo[0]));

  morra_match_driver #(.SEED1(SEED1), .SEED2(SEED2), .MAX_CYCLES(MAXC), .AVOID_ILLEGAL(1'b0)) dut_na (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_rounds_i(cfg_rounds_i),
    .INIZIA(iniz[1]), .PRIMO(primo[1]), .SECONDO(secondo[1]), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .busy_o(busy[1]), .done_o(done[1]), .result_o(result[1]), .p1_wins_o(p1w[1]), .p2_wins_o(p2w[1]),
    .draws_o(drw[1]), .invalid_o(invw[1]), .rounds_o(rnds[1]), .timeout_err_o(tmo[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Candidate from the low two LFSR bits (NO_MOVE played as ROCK); a repeated winning move is rotated.
  function automatic logic [1:0] next_move(input logic [15:0] s, input bit avoid_it, input logic [1:0] last);
    int c;
    c = int'(s[1:0]);
    if (c == 0) c = 1;
    if (avoid_it && c == int'(last)) c = (c == 3) ? 1 : c + 1;
    return 2'(c);
  endfunction

  function automatic int sat5(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_l1[i] = SEED1;
      m_l2[i] = SEED2;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_iniz"}, iniz[i], 0);
      check({tag, "_primo"}, primo[i], 0);
      check({tag, "_secondo"}, secondo[i], 0);
      check({tag, "_busy"}, busy[i], 0);
      check({tag, "_done"}, done[i], 0);
      check({tag, "_result"}, result[i], 0);
      check({tag, "_cnt"}, {p1w[i], p2w[i], drw[i], invw[i]}, 0);
      check({tag, "_rounds"}, rnds[i], 0);
      check({tag, "_tmo"}, tmo[i], 0);
    end
  endtask

  // mode 0: random outcomes, 1: three P2 manches then P1 manche with P2 match win, 2: match never decided.
  // rst_at >= 0 asserts reset during that (0-based) PLAY cycle instead of finishing the match.
  task automatic run_match(input logic [3:0] cfg, input int mode, input int rst_at);
    logic [1:0] man, par, res;
    int  rnd, p1c, p2c, drc, ivc;
    bit  fin, to;
    start_i      = 1'b1;
    cfg_rounds_i = cfg;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("cfg_iniz", iniz[i], 1);
      check("cfg_primo", primo[i], cfg[3:2]);
      check("cfg_secondo", secondo[i], cfg[1:0]);
      check("cfg_busy", busy[i], 1);
      m_win[i] = 0;
      m_wmv[i] = 2'b00;
      m_mv1[i] = next_move(m_l1[i], 1'b0, 2'b00);
      m_mv2[i] = next_move(m_l2[i], 1'b0, 2'b00);
    end
    rnd = 0; p1c = 0; p2c = 0; drc = 0; ivc = 0; fin = 0; res = 2'b00; to = 0;
    @(posedge clk); #1;
    while (!fin) begin
      for (int i = 0; i < 2; i++) begin
        check("play_iniz", iniz[i], 0);
        check("play_primo", primo[i], m_mv1[i]);
        check("play_secondo", secondo[i], m_mv2[i]);
        check("play_busy", busy[i], 1);
        check("play_done", done[i], 0);
        check("play_rounds", rnds[i], rnd);
      end
      case (mode)
        1: begin
          man = (rnd < 3) ? 2'b10 : 2'b01;
          par = (rnd < 3) ? 2'b00 : 2'b10;
        end
        2: begin
          man = 2'($urandom_range(0, 3));
          par = 2'b00;
        end
        default: begin
          man = 2'($urandom_range(0, 3));
          par = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
      endcase
      start_i = 1'($urandom_range(0, 1));
      MANCHE  = man;
      PARTITA = par;
      if (rnd == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        start_i = 1'b0;
        MANCHE  = 2'b00;
        PARTITA = 2'b00;
        model_reset();
        check_reset("midrst");
        return;
      end
      @(posedge clk); #1;
      rnd++;
      case (man)
        2'b01:   p1c++;
        2'b10:   p2c++;
        2'b11:   drc++;
        default: ivc++;
      endcase
      for (int i = 0; i < 2; i++) begin
        if (man == 2'b01) begin m_win[i] = 1; m_wmv[i] = m_mv1[i]; end
        else if (man == 2'b10) begin m_win[i] = 2; m_wmv[i] = m_mv2[i]; end
        m_l1[i]  = lfsr_adv(m_l1[i]);
        m_l2[i]  = lfsr_adv(m_l2[i]);
        m_mv1[i] = next_move(m_l1[i], (i == 0) && (m_win[i] == 1), m_wmv[i]);
        m_mv2[i] = next_move(m_l2[i], (i == 0) && (m_win[i] == 2), m_wmv[i]);
      end
      if (par != 2'b00) begin fin = 1; res = par; end
      else if (rnd == MAXC) begin fin = 1; to = 1; end
    end
    start_i = 1'b0;
    MANCHE  = 2'b00;
    PARTITA = 2'b00;
    for (int i = 0; i < 2; i++) begin
      check("end_done", done[i], 1);
      check("end_busy", busy[i], 1);
      check("end_iniz", iniz[i], 0);
      check("end_moves", {primo[i], secondo[i]}, 0);
      check("end_result", result[i], res);
      check("end_p1", p1w[i], sat5(p1c));
      check("end_p2", p2w[i], sat5(p2c));
      check("end_draws", drw[i], sat5(drc));
      check("end_invalid", invw[i], sat5(ivc));
      check("end_rounds", rnds[i], rnd);
      check("end_tmo", tmo[i], to);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check("idle_done", done[i], 0);
      check("idle_busy", busy[i], 0);
      check("idle_result", result[i], res);
      check("idle_rounds", rnds[i], rnd);
      check("idle_tmo", tmo[i], to);
    end
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    cfg_rounds_i = 4'd0;
    MANCHE       = 2'b00;
    PARTITA      = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_match(4'b0001, 1, -1);
    for (int i = 0; i < 2; i++) begin
      check("script_result", result[i], 2'b10);
      check("script_p2", p2w[i], 3);
      check("script_p1", p1w[i], 1);
      check("script_rounds", rnds[i], 4);
    end

    run_match(4'($urandom_range(0, 15)), 2, -1);
    for (int i = 0; i < 2; i++) begin
      check("timeout_flag", tmo[i], 1);
      check("timeout_rounds", rnds[i], MAXC);
    end

    run_match(4'($urandom_range(0, 15)), 2, 2);
    @(posedge clk); #1;
    check_reset("postrst");

    for (int k = 0; k < 40; k++)
      run_match(4'($urandom_range(0, 15)), 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
